// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle for alu_exec_unit: operands plus decode fields in, registered result out.
// Latency: none (wires only); the unit behind it answers one cycle or more after accept.
// Backpressure: valid/ready on both sides; in_ready gates issue, out_ready holds the result.
//
// Signals: in_valid/in_ready, alu_op, funct, a, b, shamt (issue side)
//          out_valid/out_ready, result, zero, alu_ctl, illegal (result side)
// Modports: master = issuer (register-read stage / bench), slave = alu_exec_unit.
interface alu_exec_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         alu_op;
    logic [5:0]         funct;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic [2:0]         alu_ctl;
    logic               illegal;

    modport master (
        output in_valid, alu_op, funct, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, alu_ctl, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct, a, b, shamt, out_ready,
        output in_ready, out_valid, result, zero, alu_ctl, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU control decode + execute for the multi-cycle datapath (add/sub/and/or/slt/rol/ror).
// Latency: 1 cycle for single-step ops, 1+shamt for rotates, 1+WIDTH for MULT when enabled.
// Backpressure: accepts only in IDLE; result/zero/alu_ctl/illegal held in DONE until out_ready.
//
// Ports: clk, rst_n (synchronous, active-low), bus (alu_exec_unit_if.slave).
// Optional: define ALU_EXEC_MUL_EN to add funct 011000 (MULT), a WIDTH-cycle shift-add multiply.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);

    localparam logic [2:0] CTL_AND = 3'b000;
    localparam logic [2:0] CTL_OR  = 3'b001;
    localparam logic [2:0] CTL_ADD = 3'b010;
    localparam logic [2:0] CTL_NOP = 3'b011;
    localparam logic [2:0] CTL_ROL = 3'b100;
    localparam logic [2:0] CTL_ROR = 3'b101;
    localparam logic [2:0] CTL_SUB = 3'b110;
    localparam logic [2:0] CTL_SLT = 3'b111;

`ifdef ALU_EXEC_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_ROT, S_DONE, S_MUL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ROT, S_DONE} state_t;
`endif

    typedef struct packed {
        logic [2:0] ctl;
        logic       ill;
        logic       rol;
        logic       ror;
        logic       mul;
    } dec_t;

    function automatic dec_t decode(input logic [1:0] op, input logic [5:0] fn);
        dec_t d;
        d     = '0;
        d.ctl = CTL_NOP;
        case (op)
            2'b00: d.ctl = CTL_ADD;
            2'b01: d.ctl = CTL_SUB;
            default: begin
                case (fn)
                    6'b100000: d.ctl = CTL_ADD;
                    6'b100001: begin d.ctl = CTL_ROL; d.rol = 1'b1; end
                    6'b100010: d.ctl = CTL_SUB;
                    6'b100011: begin d.ctl = CTL_ROR; d.ror = 1'b1; end
                    6'b100100: d.ctl = CTL_AND;
                    6'b100101: d.ctl = CTL_OR;
                    6'b101010: d.ctl = CTL_SLT;
`ifdef ALU_EXEC_MUL_EN
                    6'b011000: d.mul = 1'b1;
`endif
                    default:   d.ill = 1'b1;
                endcase
            end
        endcase
        return d;
    endfunction

    state_t             state, state_nxt;
    dec_t               dec;
    logic               accept;
    logic               go_rot;
    logic [WIDTH-1:0]   alu_val;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   rot_next;
    logic [SHAMT_W-1:0] cnt;
    logic               rol_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic [2:0]         ctl_q;
    logic               ill_q;
    logic               in_ready_c;
    logic               out_valid_c;

`ifdef ALU_EXEC_MUL_EN
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_nxt;
    // work holds the multiplicand, shifted left one place per step
    assign acc_nxt = acc + (mplier[0] ? work : '0);
`endif

    assign dec    = decode(bus.alu_op, bus.funct);
    assign accept = bus.in_valid && in_ready_c;
    // shamt==0 rotates finish in one step like any other op
    assign go_rot = (dec.rol || dec.ror) && (bus.shamt != '0);

    assign rot_next = rol_q ? {work[WIDTH-2:0], work[WIDTH-1]}
                            : {work[0], work[WIDTH-1:1]};

    // Single-step result, evaluated on the live issue operands
    always_comb begin
        alu_val = '0;
        case (dec.ctl)
            CTL_ADD: alu_val = bus.a + bus.b;
            CTL_SUB: alu_val = bus.a - bus.b;
            CTL_AND: alu_val = bus.a & bus.b;
            CTL_OR:  alu_val = bus.a | bus.b;
            CTL_SLT: alu_val = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            CTL_ROL, CTL_ROR: alu_val = bus.a;
            default: alu_val = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (go_rot)       state_nxt = S_ROT;
`ifdef ALU_EXEC_MUL_EN
                    else if (dec.mul) state_nxt = S_MUL;
`endif
                    else              state_nxt = S_DONE;
                end
            end
            S_ROT:  if (cnt == SHAMT_W'(1)) state_nxt = S_DONE;
`ifdef ALU_EXEC_MUL_EN
            S_MUL:  if (cnt == '1) state_nxt = S_DONE;
`endif
            S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready_c  = (state == S_IDLE);
        out_valid_c = (state == S_DONE);
    end

    // Datapath: operand capture, iteration, registered result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            ctl_q    <= CTL_NOP;
            ill_q    <= 1'b0;
            rol_q    <= 1'b0;
            work     <= '0;
            cnt      <= '0;
`ifdef ALU_EXEC_MUL_EN
            acc      <= '0;
            mplier   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ctl_q <= dec.ctl;
                        ill_q <= dec.ill;
                        rol_q <= dec.rol;
                        work  <= bus.a;
                        cnt   <= bus.shamt;
`ifdef ALU_EXEC_MUL_EN
                        acc    <= '0;
                        mplier <= bus.b;
                        if (dec.mul) cnt <= '0;
                        if (!go_rot && !dec.mul) begin
`else
                        if (!go_rot) begin
`endif
                            result_q <= alu_val;
                            zero_q   <= (alu_val == '0);
                        end
                    end
                end
                S_ROT: begin
                    work <= rot_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        result_q <= rot_next;
                        zero_q   <= (rot_next == '0);
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                S_MUL: begin
                    acc    <= acc_nxt;
                    work   <= {work[WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == '1) begin
                        result_q <= acc_nxt;
                        zero_q   <= (acc_nxt == '0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.alu_ctl   = ctl_q;
    assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table through a scoreboard, then hand sequences.
// Latency: checked per vector against the issue cycle.
// Backpressure: exercised by holding out_ready low while a result is pending.
module tb_alu_exec_unit;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_pass;
    int   n_total;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic [2:0]  ctl;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  ctl;
        logic        ill;
        int          lat;
        int          issue_cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard consumer: compares every completed handshake
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",  bus.result,  e.res);
                chk("zero",    {31'd0, bus.zero}, {31'd0, (e.res == 32'd0)});
                chk("alu_ctl", {29'd0, bus.alu_ctl}, {29'd0, e.ctl});
                chk("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
                if (e.lat > 0) chk("latency", cyc - e.issue_cyc, e.lat);
            end
        end
    end

    // Called at a tick point; returns one cycle after the accept edge
    task automatic issue(input vec_t v, input bit track, input bit chk_lat);
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) begin
            chk("issue_timeout", 32'd0, 32'd1);
            return;
        end
        bus.alu_op   = v.op;
        bus.funct    = v.fn;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.shamt    = v.sh;
        bus.in_valid = 1'b1;
        if (track) sb.push_back('{v.res, v.ctl, v.ill, (chk_lat ? v.lat : -1), cyc});
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && sb.size() != 0; k++) tick();
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        vec_t v;
        n_pass = 0;
        n_total = 0;
        cyc = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.alu_op = 2'b00;
        bus.funct = 6'd0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        bus.shamt = 5'd0;
        bus.out_ready = 1'b1;

        //            op     fn         a             b             sh     res           ctl     ill lat
        vecs.push_back('{2'b00, 6'b000000, 32'd5,        32'd7,        5'd0,  32'd12,       3'b010, 0, 1});
        vecs.push_back('{2'b01, 6'b000000, 32'h1234,     32'h1234,     5'd0,  32'd0,        3'b110, 0, 1});
        vecs.push_back('{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        3'b111, 0, 1});
        vecs.push_back('{2'b10, 6'b101010, 32'd1,        32'hFFFFFFFF, 5'd0,  32'd0,        3'b111, 0, 1});
        vecs.push_back('{2'b10, 6'b100001, 32'hF0000001, 32'd0,        5'd4,  32'h0000001F, 3'b100, 0, 5});
        vecs.push_back('{2'b10, 6'b100011, 32'hABCD0000, 32'd0,        5'd0,  32'hABCD0000, 3'b101, 0, 1});
        vecs.push_back('{2'b10, 6'b100011, 32'h000000AB, 32'd0,        5'd8,  32'hAB000000, 3'b101, 0, 9});
        vecs.push_back('{2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 3'b000, 0, 1});
        vecs.push_back('{2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 3'b001, 0, 1});
        vecs.push_back('{2'b10, 6'b100000, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        3'b010, 0, 1});
        vecs.push_back('{2'b10, 6'b100010, 32'd0,        32'd1,        5'd0,  32'hFFFFFFFF, 3'b110, 0, 1});
        vecs.push_back('{2'b10, 6'b000111, 32'd9,        32'd3,        5'd0,  32'd0,        3'b011, 1, 1});
        vecs.push_back('{2'b11, 6'b100000, 32'd3,        32'd4,        5'd0,  32'd7,        3'b010, 0, 1});
        vecs.push_back('{2'b10, 6'b100001, 32'd1,        32'd0,        5'd31, 32'h80000000, 3'b100, 0, 32});
        vecs.push_back('{2'b10, 6'b100011, 32'd1,        32'd0,        5'd1,  32'h80000000, 3'b101, 0, 2});
`ifdef ALU_EXEC_MUL_EN
        vecs.push_back('{2'b10, 6'b011000, 32'd6,        32'd7,        5'd0,  32'd42,       3'b011, 0, 33});
        vecs.push_back('{2'b10, 6'b011000, 32'h00010001, 32'h0000FFFF, 5'd0,  32'hFFFFFFFF, 3'b011, 0, 33});
`else
        vecs.push_back('{2'b10, 6'b011000, 32'd6,        32'd7,        5'd0,  32'd0,        3'b011, 1, 1});
`endif

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result",    bus.result, 32'd0);
        chk("rst_zero",      {31'd0, bus.zero}, 32'd0);
        chk("rst_alu_ctl",   {29'd0, bus.alu_ctl}, 32'd3);
        chk("rst_illegal",   {31'd0, bus.illegal}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);

        // Table through the scoreboard
        for (int i = 0; i < vecs.size(); i++) issue(vecs[i], 1'b1, 1'b1);
        drain();

        // ROL by 4: busy for four cycles, result on the fifth
        v = '{2'b10, 6'b100001, 32'hF0000001, 32'd0, 5'd4, 32'h0000001F, 3'b100, 0, 5};
        issue(v, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("rol_busy", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
            tick();
        end
        chk("rol_done", {30'd0, bus.in_ready, bus.out_valid}, 32'd1);
        drain();

        // Backpressure: result held, new issue ignored
        bus.out_ready = 1'b0;
        v = '{2'b00, 6'b000000, 32'd5, 32'd7, 5'd0, 32'd12, 3'b010, 0, 1};
        issue(v, 1'b1, 1'b0);
        bus.alu_op = 2'b01;
        bus.a = 32'd100;
        bus.b = 32'd1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_result",    bus.result, 32'd12);
            chk("bp_zero",      {31'd0, bus.zero}, 32'd0);
            chk("bp_in_ready",  {31'd0, bus.in_ready}, 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        drain();

        // Reset during the 10th ROT cycle of ROR by 31
        v = '{2'b10, 6'b100011, 32'h00000003, 32'd0, 5'd31, 32'd0, 3'b101, 0, 32};
        issue(v, 1'b0, 1'b0);
        repeat (9) tick();
        chk("rot_mid_ctl", {29'd0, bus.alu_ctl}, 32'd5);
        chk("rot_mid_busy", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_result",    bus.result, 32'd0);
        chk("abort_zero",      {31'd0, bus.zero}, 32'd0);
        chk("abort_alu_ctl",   {29'd0, bus.alu_ctl}, 32'd3);
        chk("abort_illegal",   {31'd0, bus.illegal}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("abort_quiet",    {31'd0, bus.out_valid}, 32'd0);

        // Recovery after the abort
        v = '{2'b00, 6'b000000, 32'd40, 32'd2, 5'd0, 32'd42, 3'b010, 0, 1};
        issue(v, 1'b1, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
